// File: rtl/exec_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : exec_unit_if
//  Description : Bundle between the 4x8 register bank / controller and the
//                execute stage: bank read values and issue fields in,
//                write-back, handshake and flag outputs out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface exec_unit_if;
  // Register bank read ports
  logic [7:0] r0;
  logic [7:0] r1;
  logic [7:0] r2;
  logic [7:0] r3;
  // Instruction issue
  logic       start;
  logic [3:0] opcode;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic [1:0] dst;
  // Write-back and status
  logic [7:0] alu_result;
  logic       write;
  logic [1:0] out_sel;
  logic       busy;
  logic       done;
  logic       zero;
  logic       carry;
  logic       err;

  // Issuing side (bank plus controller)
  modport master (
    output r0, r1, r2, r3, start, opcode, src_a, src_b, dst,
    input  alu_result, write, out_sel, busy, done, zero, carry, err
  );

  // Execute stage
  modport slave (
    input  r0, r1, r2, r3, start, opcode, src_a, src_b, dst,
    output alu_result, write, out_sel, busy, done, zero, carry, err
  );
endinterface
`default_nettype wire

// File: rtl/exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : exec_unit
//  Description : Execute stage behind the 4x8-bit register bank. Snapshots
//                operands at issue, runs single-cycle ALU ops or 8-step
//                shift-add MUL / restoring DIV, and issues a one-cycle
//                write-back pulse with registered zero/carry/error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_unit #(
  parameter int W    = 8,
  parameter int ITER = 8
) (
  input  wire logic    clk,
  input  wire logic    rst,
  exec_unit_if.slave   bus
);

  localparam int CW = $clog2(ITER);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_INC = 4'h8;
  localparam logic [3:0] OP_DEC = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;
  localparam logic [3:0] OP_DIV = 4'hB;
  localparam logic [3:0] OP_CMP = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [3:0]     op_q, op_d;
  logic [1:0]     dst_q, dst_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   hi_q, hi_d;   // MUL: high product half / DIV: remainder
  logic [W-1:0]   lo_q, lo_d;   // MUL: multiplier+low half / DIV: quotient
  logic [W-1:0]   alu_result_q, alu_result_d;
  logic           write_q, write_d;
  logic [1:0]     out_sel_q, out_sel_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           zero_q, zero_d;
  logic           carry_q, carry_d;
  logic           err_q, err_d;

  logic [W-1:0]   w_a, w_b;
  logic [W-1:0]   w_alu_res;
  logic           w_alu_c;
  logic [W:0]     w_mul_sum;
  logic [W-1:0]   w_mul_hi, w_mul_lo;
  logic [W:0]     w_div_shift;
  logic           w_div_ge;
  logic [W-1:0]   w_div_hi, w_div_lo;
  logic           w_is_iter_op, w_is_rsvd;

  // Select the live bank values addressed by the issue fields
  always_comb begin
    w_a = bus.r0;
    w_b = bus.r0;
    case (bus.src_a)
      2'd0:    w_a = bus.r0;
      2'd1:    w_a = bus.r1;
      2'd2:    w_a = bus.r2;
      default: w_a = bus.r3;
    endcase
    case (bus.src_b)
      2'd0:    w_b = bus.r0;
      2'd1:    w_b = bus.r1;
      2'd2:    w_b = bus.r2;
      default: w_b = bus.r3;
    endcase
  end

  // Single-cycle ALU on the live operands; used only at acceptance
  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    case (bus.opcode)
      OP_ADD:         {w_alu_c, w_alu_res} = {1'b0, w_a} + {1'b0, w_b};
      OP_SUB, OP_CMP: {w_alu_c, w_alu_res} = {1'b0, w_a} - {1'b0, w_b};
      OP_AND:         w_alu_res = w_a & w_b;
      OP_OR:          w_alu_res = w_a | w_b;
      OP_XOR:         w_alu_res = w_a ^ w_b;
      OP_NOT:         w_alu_res = ~w_a;
      OP_SHL: begin
        w_alu_res = {w_a[W-2:0], 1'b0};
        w_alu_c   = w_a[W-1];
      end
      OP_SHR: begin
        w_alu_res = {1'b0, w_a[W-1:1]};
        w_alu_c   = w_a[0];
      end
      OP_INC:         {w_alu_c, w_alu_res} = {1'b0, w_a} + (W+1)'(1);
      OP_DEC:         {w_alu_c, w_alu_res} = {1'b0, w_a} - (W+1)'(1);
      OP_MOV:         w_alu_res = w_b;
      default: begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
      end
    endcase
  end

  // One iteration step of shift-add multiply and restoring divide
  always_comb begin
    // MUL: add A into the high half when the current multiplier bit is set,
    // then shift the {hi, lo} pair right by one.
    w_mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    w_mul_hi    = w_mul_sum[W:1];
    w_mul_lo    = {w_mul_sum[0], lo_q[W-1:1]};
    // DIV: shift the next dividend bit into the remainder and subtract B
    // when it fits. With B==0 every trial fits, giving an all-ones quotient.
    w_div_shift = {hi_q, lo_q[W-1]};
    w_div_ge    = (w_div_shift >= {1'b0, b_q});
    w_div_hi    = w_div_ge ? (w_div_shift[W-1:0] - b_q) : w_div_shift[W-1:0];
    w_div_lo    = {lo_q[W-2:0], w_div_ge};
  end

  assign w_is_iter_op = (bus.opcode == OP_MUL) || (bus.opcode == OP_DIV);
  assign w_is_rsvd    = (bus.opcode == 4'hE) || (bus.opcode == 4'hF);

  // Next-state and registered-output logic for IDLE -> (ITER) -> WB
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    dst_d        = dst_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    alu_result_d = alu_result_q;
    write_d      = write_q;
    out_sel_d    = out_sel_q;
    busy_d       = busy_q;
    done_d       = done_q;
    zero_d       = zero_q;
    carry_d      = carry_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        write_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        if (bus.start) begin
          a_d    = w_a;
          b_d    = w_b;
          op_d   = bus.opcode;
          dst_d  = bus.dst;
          busy_d = 1'b1;
          if (w_is_iter_op) begin
            state_d = S_ITER;
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = (bus.opcode == OP_MUL) ? w_b : w_a;
          end else begin
            state_d   = S_WB;
            done_d    = 1'b1;
            out_sel_d = bus.dst;
            if (w_is_rsvd) begin
              // Reserved opcodes only raise err; zero/carry keep their value
              write_d = 1'b0;
              err_d   = 1'b1;
            end else begin
              alu_result_d = w_alu_res;
              zero_d       = (w_alu_res == '0);
              carry_d      = w_alu_c;
              err_d        = 1'b0;
              write_d      = (bus.opcode != OP_CMP);
            end
          end
        end
      end

      S_ITER: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q == OP_MUL) begin
          hi_d = w_mul_hi;
          lo_d = w_mul_lo;
        end else begin
          hi_d = w_div_hi;
          lo_d = w_div_lo;
        end
        if (cnt_q == CW'(ITER - 1)) begin
          state_d   = S_WB;
          done_d    = 1'b1;
          write_d   = 1'b1;
          out_sel_d = dst_q;
          if (op_q == OP_MUL) begin
            alu_result_d = w_mul_lo;
            zero_d       = (w_mul_lo == '0);
            carry_d      = (w_mul_hi != '0);
            err_d        = 1'b0;
          end else if (b_q == '0) begin
            alu_result_d = '1;
            zero_d       = 1'b0;
            carry_d      = 1'b0;
            err_d        = 1'b1;
          end else begin
            alu_result_d = w_div_lo;
            zero_d       = (w_div_lo == '0);
            carry_d      = 1'b0;
            err_d        = 1'b0;
          end
        end
      end

      S_WB: begin
        state_d = S_IDLE;
        write_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        write_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; active-low synchronous reset drops any op
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      dst_q        <= '0;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      alu_result_q <= '0;
      write_q      <= 1'b0;
      out_sel_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      zero_q       <= 1'b0;
      carry_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      dst_q        <= dst_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      alu_result_q <= alu_result_d;
      write_q      <= write_d;
      out_sel_q    <= out_sel_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      zero_q       <= zero_d;
      carry_q      <= carry_d;
      err_q        <= err_d;
    end
  end

  assign bus.alu_result = alu_result_q;
  assign bus.write      = write_q;
  assign bus.out_sel    = out_sel_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.zero       = zero_q;
  assign bus.carry      = carry_q;
  assign bus.err        = err_q;

endmodule
`default_nettype wire

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage that sits directly downstream of the 4x8-bit register bank.
- Reads the bank's four outputs, latches the selected operands on an issued instruction, and computes single-cycle or iterative (8-cycle MUL/DIV) results.
- Drives the bank's write-back interface (alu_result, write, out_sel) with a one-cycle write pulse.
- Keeps zero/carry/error flags for the controller.

Parameters:
- W, 8, datapath width; the bank is 8 bits, so only 8 is supported.
- ITER, 8, iteration count for MUL/DIV; must equal W.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous active-low reset: sampled on rising edge of clk, active when 0.
- r0,r1,r2,r3  input  8 each  register bank outputs for bank[0..3].
- start  input  1  issue strobe; sampled only in IDLE.
- opcode  input  4  operation select (table below).
- src_a, src_b  input  2 each  bank index of operand A / B.
- dst  input  2  destination bank index.
- alu_result  output  8  write-back data.
- write  output  1  one-cycle write strobe to the bank.
- out_sel  output  2  write-back bank index.
- busy  output  1  high from the cycle after acceptance through the WB cycle.
- done  output  1  one-cycle completion pulse, coincident with WB.
- zero, carry, err  output  1 each  registered flags.

Behaviour:
- Reset (rst=0 at a rising edge): state=IDLE. alu_result=0, write=0, out_sel=0, busy=0, done=0, zero=0, carry=0, err=0. Reset overrides everything, including mid-MUL/DIV; partial results are discarded and no write is issued.
- All outputs are registered.
- FSM states: IDLE, ITER, WB.
- IDLE + start=1:
  - Latch A=r[src_a], B=r[src_b], dst, opcode at that edge.
  - Single-cycle ops go to WB; results and flags are registered at the same edge.
  - MUL/DIV go to ITER with count=0.
  - IDLE + start=0 stays in IDLE.
- Operands are snapshotted at acceptance. Later bank changes do not affect an in-flight op.
- ITER: one shift-add (MUL) or restoring-subtract (DIV) step per cycle. After 8 steps, go to WB with the result registered. start is ignored.
- WB (exactly one cycle):
  - done=1; busy=1.
  - write=1 unless the op is CMP or reserved.
  - out_sel=dst; alu_result holds the result.
  - Next state is IDLE; write, done and busy drop to 0.
  - start sampled during WB is ignored. The earliest next acceptance is the cycle after WB.
- Latency, start edge to write cycle: single-cycle ops = 1 cycle (write high the next cycle); MUL/DIV = 9 cycles. Throughput: one op per 2 cycles (single-cycle ops) or per 10 cycles (MUL/DIV).
- Flags update at entry to WB only; they hold otherwise.
  - zero = (8-bit result == 0).
  - err = 0 except where stated below.
- Opcodes (arithmetic is mod 256):
  - 0 ADD: A+B; carry = bit 8.
  - 1 SUB: A-B; carry = borrow (A<B).
  - 2 AND, 3 OR, 4 XOR: carry=0.
  - 5 NOT: ~A; carry=0.
  - 6 SHL: A<<1; carry=A[7].
  - 7 SHR: logical A>>1; carry=A[0].
  - 8 INC: A+1; carry on FF->00.
  - 9 DEC: A-1; carry on 00->FF.
  - A MUL: low byte of A*B; carry = (high byte != 0).
  - B DIV: quotient A/B; carry=0. If B==0: result=FF, err=1, still 8 iterations, write still issued.
  - C CMP: flags as SUB; write=0.
  - D MOV: result=B; carry=0.
  - E,F reserved: go to WB with write=0, done=1, err=1, zero/carry unchanged.
- src_a==src_b and dst==src are all legal.
- out_sel and alu_result are held at their last values in IDLE; write=0 there.

Test Plan:
- Reset: drive rst=0 for 2 cycles with start=1 -> all outputs 0, no write; release, IDLE, busy=0.
- ADD: r1=0xF0, r2=0x20, opcode=0, src_a=1, src_b=2, dst=3, start one cycle -> next cycle write=1, out_sel=3, alu_result=0x10, carry=1, zero=0, done=1; following cycle write=0, busy=0.
- MUL: r0=0x12, r1=0x0E, opcode=A, dst=2 -> busy for 9 cycles; write only on cycle 9 with alu_result=0xFC, carry=0. Then r0=0x10, r1=0x10 -> alu_result=0x00, zero=1, carry=1.
- DIV: r0=200, r1=7 -> alu_result=28, err=0, at cycle 9. Then r1=0 -> alu_result=0xFF, err=1, write=1.
- Busy and snapshot: during MUL, pulse start with opcode=0 and change r0 -> ignored; MUL result uses the original operands; exactly one write.
- CMP: r0=0x05, r1=0x05, opcode=C -> done=1, write=0, zero=1, carry=0.
- Reserved: opcode=F -> done=1, write=0, err=1.
- Reset mid-op: assert rst=0 at ITER step 4 -> IDLE next cycle, no write ever issued, flags 0.
